// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Opcodes, flag bit positions and FSM encodings for alu_seq.
// Revision: 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  localparam int OP_W   = 5;
  localparam int FLAG_W = 5;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD  = 5'd0;
  localparam op_t OP_SUB  = 5'd1;
  localparam op_t OP_CMP  = 5'd2;
  localparam op_t OP_AND  = 5'd3;
  localparam op_t OP_OR   = 5'd4;
  localparam op_t OP_XOR  = 5'd5;
  localparam op_t OP_NOT  = 5'd6;
  localparam op_t OP_LSH  = 5'd7;
  localparam op_t OP_RSH  = 5'd8;
  localparam op_t OP_ARSH = 5'd9;
  localparam op_t OP_MUL  = 5'd10;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_single(input op_t op);
    return op <= OP_NOT;
  endfunction

  function automatic logic is_shift(input op_t op);
    return (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_if
// Brief   : Operand/result handshake bundle between datapath and alu_seq.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic                              in_valid;
  logic                              in_ready;
  logic [WIDTH-1:0]                  Rsrc;
  logic [WIDTH-1:0]                  Rdest;
  logic [alu_seq_pkg::OP_W-1:0]      OpCode;
  logic                              out_valid;
  logic                              out_ready;
  logic [WIDTH-1:0]                  Out;
  logic                              out_wen;
  logic                              out_illegal;
  logic [alu_seq_pkg::FLAG_W-1:0]    Flags;

  modport master (
    output in_valid, Rsrc, Rdest, OpCode, out_ready,
    input  in_ready, out_valid, Out, out_wen, out_illegal, Flags
  );

  modport slave (
    input  in_valid, Rsrc, Rdest, OpCode, out_ready,
    output in_ready, out_valid, Out, out_wen, out_illegal, Flags
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_comb.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_comb
// Brief   : Single-cycle datapath (ADD..NOT): result, next flags, write enable.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]   op_i,
  input  logic [WIDTH-1:0]  a_i,
  input  logic [WIDTH-1:0]  b_i,
  input  logic [FLAG_W-1:0] flags_i,
  output logic [WIDTH-1:0]  res_o,
  output logic [FLAG_W-1:0] flags_o,
  output logic              wen_o
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, a_i} + {1'b0, b_i};
  assign w_diff = {1'b0, a_i} - {1'b0, b_i};

  always_comb begin
    res_o   = '0;
    flags_o = flags_i;
    wen_o   = 1'b1;
    case (op_i)
      OP_ADD: begin
        res_o           = w_sum[WIDTH-1:0];
        flags_o[FLAG_C] = w_sum[WIDTH];
        flags_o[FLAG_F] = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        res_o           = w_diff[WIDTH-1:0];
        flags_o[FLAG_C] = w_diff[WIDTH];
        flags_o[FLAG_F] = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res_o[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_CMP: begin
        res_o           = w_diff[WIDTH-1:0];
        wen_o           = 1'b0;
        flags_o[FLAG_L] = w_diff[WIDTH];
        flags_o[FLAG_N] = $signed(a_i) < $signed(b_i);
        flags_o[FLAG_Z] = (a_i == b_i);
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NOT:  res_o = ~a_i;
      default: wen_o = 1'b0;
    endcase
    if ((op_i != OP_CMP) && is_single(op_i)) begin
      flags_o[FLAG_Z] = (res_o == '0);
      flags_o[FLAG_N] = res_o[WIDTH-1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq
// Brief   : Registered ALU with handshake, persistent flags, serial shifts/MUL.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  localparam int CNT_W = SHAMT_W + 1;

  logic [1:0]        state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              wen_q, wen_d;
  logic              ill_q, ill_d;

  logic              w_in_ready;
  logic              w_accept;
  logic [SHAMT_W-1:0] w_k;
  logic [WIDTH-1:0]  w_comb_res;
  logic [FLAG_W-1:0] w_comb_flags;
  logic              w_comb_wen;
  logic [WIDTH-1:0]  w_shift_val;
  logic              w_shift_bit;
  logic [WIDTH-1:0]  w_mul_sum;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i    (bus.OpCode),
    .a_i     (bus.Rdest),
    .b_i     (bus.Rsrc),
    .flags_i (flags_q),
    .res_o   (w_comb_res),
    .flags_o (w_comb_flags),
    .wen_o   (w_comb_wen)
  );

  assign w_in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_k        = bus.Rsrc[SHAMT_W-1:0];

  // One bit position per BUSY cycle; the bit leaving the word is the carry candidate.
  always_comb begin
    w_shift_val = {a_q[WIDTH-2:0], 1'b0};
    w_shift_bit = a_q[WIDTH-1];
    if (op_q == OP_RSH) begin
      w_shift_val = {1'b0, a_q[WIDTH-1:1]};
      w_shift_bit = a_q[0];
    end else if (op_q == OP_ARSH) begin
      w_shift_val = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      w_shift_bit = a_q[0];
    end
  end

  assign w_mul_sum = acc_q + (b_q[0] ? a_q : '0);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    flags_d = flags_q;
    wen_d   = wen_q;
    ill_d   = ill_q;

    case (state_q)
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (op_q == OP_MUL) begin
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
          acc_d = w_mul_sum;
        end else begin
          a_d   = w_shift_val;
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          wen_d   = 1'b1;
          ill_d   = 1'b0;
          if (op_q == OP_MUL) begin
            out_d = w_mul_sum;
          end else begin
            out_d           = w_shift_val;
            flags_d[FLAG_C] = w_shift_bit;
          end
          flags_d[FLAG_Z] = (out_d == '0);
          flags_d[FLAG_N] = out_d[WIDTH-1];
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    if (w_accept) begin
      op_d  = bus.OpCode;
      a_d   = bus.Rdest;
      b_d   = bus.Rsrc;
      acc_d = '0;
      if (is_single(bus.OpCode)) begin
        state_d = S_DONE;
        out_d   = w_comb_res;
        flags_d = w_comb_flags;
        wen_d   = w_comb_wen;
        ill_d   = 1'b0;
      end else if (is_shift(bus.OpCode) && (w_k == '0)) begin
        state_d         = S_DONE;
        out_d           = bus.Rdest;
        flags_d[FLAG_Z] = (bus.Rdest == '0);
        flags_d[FLAG_N] = bus.Rdest[WIDTH-1];
        wen_d           = 1'b1;
        ill_d           = 1'b0;
      end else if (is_shift(bus.OpCode)) begin
        state_d = S_BUSY;
        cnt_d   = {1'b0, w_k};
      end else if (bus.OpCode == OP_MUL) begin
        state_d = S_BUSY;
        cnt_d   = CNT_W'(WIDTH);
      end else begin
        state_d = S_DONE;
        out_d   = '0;
        wen_d   = 1'b0;
        ill_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      flags_q <= '0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      wen_q   <= wen_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.Out         = out_q;
  assign bus.out_wen     = wen_q;
  assign bus.out_illegal = ill_q;
  assign bus.Flags       = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_seq
// Brief   : Directed and random checks of alu_seq against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: at most one op in flight; its result appears at cycle m_valid_at.
  int          cyc = 0;
  bit          m_pending = 0;
  int          m_valid_at = 0;
  logic [4:0]  m_op;
  logic [15:0] m_res;
  bit          m_wen, m_ill;
  logic [4:0]  m_fprev = '0, m_fafter = '0;

  logic        s_ir, s_ov, s_wen, s_ill;
  logic [15:0] s_out;
  logic [4:0]  s_fl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Flags {C,L,F,Z,N}
  function automatic void ref_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] fin, output logic [15:0] res, output logic [4:0] fo,
                                 output bit wen, output bit ill, output int iters);
    int sa, sb, s, k;
    int unsigned p;
    logic signed [15:0] a_s;
    sa = int'($signed(a));
    sb = int'($signed(b));
    a_s = a;
    k = int'(b[3:0]);
    fo = fin; wen = 1; ill = 0; iters = 0; res = '0;
    case (op)
      5'd0: begin s = int'(a) + int'(b); res = a + b; fo[4] = (s > 65535);
                  s = sa + sb; fo[2] = (s > 32767) || (s < -32768); end
      5'd1: begin res = a - b; fo[4] = (a < b);
                  s = sa - sb; fo[2] = (s > 32767) || (s < -32768); end
      5'd2: begin res = a - b; wen = 0; fo[3] = (a < b); fo[0] = (sa < sb); fo[1] = (a == b); end
      5'd3: res = a & b;
      5'd4: res = a | b;
      5'd5: res = a ^ b;
      5'd6: res = ~a;
      5'd7: begin res = a << k; iters = k; if (k != 0) fo[4] = a[16-k]; end
      5'd8: begin res = a >> k; iters = k; if (k != 0) fo[4] = a[k-1]; end
      5'd9: begin res = a_s >>> k; iters = k; if (k != 0) fo[4] = a[k-1]; end
      5'd10: begin p = int'(a) * int'(b); res = p[15:0]; iters = 16; end
      default: begin wen = 0; ill = 1; end
    endcase
    if (op != 5'd2 && op <= 5'd10) begin
      fo[1] = (res == 16'h0);
      fo[0] = res[15];
    end
  endfunction

  task automatic model_step(input bit iv, input logic [4:0] op, input logic [15:0] a,
                            input logic [15:0] b, input bit ordy);
    bit v, consumed, acc;
    logic [4:0] fo;
    int iters;
    v = m_pending && (cyc >= m_valid_at);
    consumed = v && ordy;
    acc = iv && (!m_pending || consumed);
    if (consumed) m_pending = 0;
    if (acc) begin
      ref_op(op, a, b, m_fafter, m_res, fo, m_wen, m_ill, iters);
      m_op = op;
      m_pending = 1;
      m_valid_at = cyc + 1 + iters;
      m_fprev = m_fafter;
      m_fafter = fo;
    end
    cyc++;
  endtask

  task automatic cycle(input bit iv, input logic [4:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit ordy);
    bit exp_ov;
    @(negedge clk);
    bus.in_valid = iv; bus.OpCode = op; bus.Rdest = a; bus.Rsrc = b; bus.out_ready = ordy;
    #1;
    s_ir = bus.in_ready; s_ov = bus.out_valid; s_out = bus.Out;
    s_wen = bus.out_wen; s_ill = bus.out_illegal; s_fl = bus.Flags;
    exp_ov = m_pending && (cyc >= m_valid_at);
    chk("in_ready", 32'(s_ir), 32'(!m_pending || (exp_ov && ordy)));
    chk("out_valid", 32'(s_ov), 32'(exp_ov));
    chk("Flags", 32'(s_fl), 32'((m_pending && cyc < m_valid_at) ? m_fprev : m_fafter));
    if (exp_ov) begin
      chk("out_wen", 32'(s_wen), 32'(m_wen));
      chk("out_illegal", 32'(s_ill), 32'(m_ill));
      if (m_op != 5'd2) chk("Out", 32'(s_out), 32'(m_res));
    end
    model_step(iv, op, a, b, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_pending = 0; m_fprev = '0; m_fafter = '0;
  endtask

  function automatic logic [15:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] r; logic [4:0] f; bit w, il; int it;
    logic [4:0] fl_before;

    // Pin the model with hand-computed values.
    ref_op(5'd9, 16'h8000, 16'd3, 5'h00, r, f, w, il, it);
    chk("model_arsh", 32'(r), 32'hF000);
    chk("model_arsh_iters", 32'(it), 32'd3);
    ref_op(5'd10, 16'h0123, 16'h0010, 5'h00, r, f, w, il, it);
    chk("model_mul", 32'(r), 32'h1230);
    ref_op(5'd0, 16'h7FFF, 16'h0001, 5'h00, r, f, w, il, it);
    chk("model_add_flags", 32'(f), 32'h05);
    ref_op(5'd1, 16'h0000, 16'h0001, 5'h00, r, f, w, il, it);
    chk("model_sub_flags", 32'(f), 32'h11);

    bus.in_valid = 0; bus.OpCode = 0; bus.Rdest = 0; bus.Rsrc = 0; bus.out_ready = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Reset state
    cycle(0, 5'd0, 16'h0, 16'h0, 0);
    chk("rst_out_valid", 32'(s_ov), 32'd0);
    chk("rst_Out", 32'(s_out), 32'd0);
    chk("rst_Flags", 32'(s_fl), 32'd0);
    chk("rst_in_ready", 32'(s_ir), 32'd1);
    chk("rst_wen", 32'(s_wen), 32'd0);

    // ADD overflow
    cycle(1, 5'd0, 16'h7FFF, 16'h0001, 0);
    cycle(0, 5'd0, 16'h0, 16'h0, 0);
    chk("t1_valid", 32'(s_ov), 32'd1);
    chk("t1_Out", 32'(s_out), 32'h8000);
    chk("t1_Flags", 32'(s_fl), 32'h05);
    chk("t1_wen", 32'(s_wen), 32'd1);

    // SUB back-to-back, then CMP
    cycle(1, 5'd1, 16'h0000, 16'h0001, 1);
    chk("t2_accept_in_done", 32'(s_ir), 32'd1);
    cycle(1, 5'd2, 16'h0003, 16'hFFFE, 1);
    chk("t2_sub_Out", 32'(s_out), 32'hFFFF);
    chk("t2_sub_Flags", 32'(s_fl), 32'h11);
    cycle(0, 5'd0, 16'h0, 16'h0, 0);
    chk("t2_cmp_Flags", 32'(s_fl), 32'h18);
    chk("t2_cmp_wen", 32'(s_wen), 32'd0);

    // ARSH latency
    cycle(1, 5'd9, 16'h8000, 16'd3, 1);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 5'd0, 16'h0, 16'h0, 0);
      if (i < 4) chk("t3_busy_in_ready", 32'(s_ir), 32'd0);
      chk("t3_valid_timing", 32'(s_ov), 32'(i == 4));
    end
    chk("t3_Out", 32'(s_out), 32'hF000);
    chk("t3_Flags", 32'(s_fl), 32'h09);

    // MUL latency and hold
    cycle(1, 5'd10, 16'h0123, 16'h0010, 1);
    for (int i = 1; i <= 17; i++) begin
      cycle(0, 5'd0, 16'h0, 16'h0, 0);
      chk("t4_valid_timing", 32'(s_ov), 32'(i == 17));
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 5'd0, 16'h0, 16'h0, 0);
      chk("t4_hold_Out", 32'(s_out), 32'h1230);
      chk("t4_hold_Flags", 32'(s_fl), 32'h08);
    end

    // Back-to-back ADD 2+2
    cycle(1, 5'd0, 16'h0002, 16'h0002, 1);
    chk("t5_accept", 32'(s_ir), 32'd1);
    cycle(0, 5'd0, 16'h0, 16'h0, 0);
    chk("t5_valid", 32'(s_ov), 32'd1);
    chk("t5_Out", 32'(s_out), 32'h0004);

    // Illegal opcode
    fl_before = s_fl;
    cycle(1, 5'b11111, 16'h1234, 16'h5678, 1);
    cycle(0, 5'd0, 16'h0, 16'h0, 1);
    chk("t6_Out", 32'(s_out), 32'd0);
    chk("t6_illegal", 32'(s_ill), 32'd1);
    chk("t6_wen", 32'(s_wen), 32'd0);
    chk("t6_Flags", 32'(s_fl), 32'(fl_before));

    // Reset in the middle of a MUL
    cycle(1, 5'd0, 16'h7FFF, 16'h0001, 1);
    cycle(1, 5'd10, 16'h0123, 16'h0010, 1);
    for (int i = 0; i < 7; i++) cycle(0, 5'd0, 16'h0, 16'h0, 0);
    do_reset();
    cycle(0, 5'd0, 16'h0, 16'h0, 0);
    chk("t4r_valid", 32'(s_ov), 32'd0);
    chk("t4r_Flags", 32'(s_fl), 32'd0);
    chk("t4r_in_ready", 32'(s_ir), 32'd1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [4:0] op;
      if (i % 997 == 996) do_reset();
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
      cycle(1'($urandom_range(0, 3) != 0), op, rnd_val(), rnd_val(),
            1'($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
